// File: rtl/pio_in_pkg.sv
// ============================================================================
// Module      : pio_in_pkg
// Description : Shared constants and helpers for the Avalon input PIO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pio_in_pkg;

    // Word addresses of the slave register map
    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    // Edge-type selector values for the EDGE_TYPE parameter
    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // Bits needed to hold values 0..value-1; at least 1 so vectors are never empty
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage : pio_in_pkg

`default_nettype wire

// File: rtl/avalon_pio_in_irq_if.sv
// ============================================================================
// Module      : avalon_pio_in_irq_if
// Description : Avalon-MM slave bus (2-bit word address, 32-bit data).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface avalon_pio_in_irq_if;

    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );

endinterface : avalon_pio_in_irq_if

`default_nettype wire

// File: rtl/pio_in_debounce.sv
// ============================================================================
// Module      : pio_in_debounce
// Description : Single-bit debouncer; q follows d only after d has differed
//               from q for DEBOUNCE_CYCLES consecutive clocks.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pio_in_debounce
    import pio_in_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    localparam int c_cnt_width = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [c_cnt_width-1:0] c_cnt_last = c_cnt_width'(DEBOUNCE_CYCLES - 1);

    logic [c_cnt_width-1:0] r_count;
    logic                   r_stable;

    // Any return to the stable value restarts the count, so short glitches never pass
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count  <= '0;
            r_stable <= 1'b0;
        end else if (d == r_stable) begin
            r_count  <= '0;
        end else if (r_count >= c_cnt_last) begin
            r_stable <= d;
            r_count  <= '0;
        end else begin
            r_count  <= r_count + 1'b1;
        end
    end

    assign q = r_stable;

endmodule : pio_in_debounce

`default_nettype wire

// File: rtl/avalon_pio_in_irq.sv
// ============================================================================
// Module      : avalon_pio_in_irq
// Description : Avalon-MM input PIO with sticky edge capture and maskable
//               level interrupt. Define PIO_DEBOUNCE_EN to debounce inputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module avalon_pio_in_irq
    import pio_in_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int EDGE_TYPE       = 0,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                clk,
    input  logic                reset_n,
    avalon_pio_in_irq_if.slave  bus,
    input  logic [WIDTH-1:0]    in_port,
    output logic                irq
);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_edge_capture;
    logic [WIDTH-1:0] r_irq_mask;
    logic [31:0]      r_readdata;

    logic [WIDTH-1:0] w_level;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_read_mux;
    logic             w_write;
    logic             w_read;

    // Two-flop synchroniser for the asynchronous external inputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= in_port;
            r_s2 <= r_s1;
        end
    end

`ifdef PIO_DEBOUNCE_EN
    for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
        pio_in_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (r_s2[i]),
            .q       (w_level[i])
        );
    end
`else
    assign w_level = r_s2;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev <= '0;
        end else begin
            r_prev <= w_level;
        end
    end

    always_comb begin
        w_rise = w_level & ~r_prev;
        w_fall = ~w_level & r_prev;
        case (EDGE_TYPE)
            EDGE_RISING:  w_edge = w_rise;
            EDGE_FALLING: w_edge = w_fall;
            default:      w_edge = w_rise | w_fall;
        endcase
    end

    assign w_write = bus.chipselect && !bus.write_n;
    assign w_read  = bus.chipselect && bus.write_n;
    assign w_clr   = {WIDTH{w_write && (bus.address == ADDR_EDGE_CAP)}} & bus.writedata[WIDTH-1:0];

    // A fresh edge outranks a same-cycle write-1-to-clear so no event is lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edge_capture <= '0;
        end else begin
            r_edge_capture <= w_edge | (r_edge_capture & ~w_clr);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_mask <= '0;
        end else if (w_write && (bus.address == ADDR_IRQ_MASK)) begin
            r_irq_mask <= bus.writedata[WIDTH-1:0];
        end
    end

    always_comb begin
        w_read_mux = '0;
        case (bus.address)
            ADDR_DATA:     w_read_mux[WIDTH-1:0] = w_level;
            ADDR_IRQ_MASK: w_read_mux[WIDTH-1:0] = r_irq_mask;
            ADDR_EDGE_CAP: w_read_mux[WIDTH-1:0] = r_edge_capture;
            default:       w_read_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= '0;
        end else if (w_read) begin
            r_readdata <= w_read_mux;
        end
    end

    assign bus.readdata = r_readdata;
    assign irq          = |(r_edge_capture & r_irq_mask);

endmodule : avalon_pio_in_irq

`default_nettype wire
